scientific_alu: RTL and testbench

SCIENTIFIC_ALU -- requirements
Module: scientific_alu

---
 rtl/scientific_alu.sv | 170 +++++++++++++++++
 tb/tb_scientific_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/scientific_alu.sv
// Scientific ALU: single-cycle IEEE-754 binary64 add/sub/mul, sign ops,
// min/max/compare and operand pass-through, with one registered output stage.
// Arithmetic truncates toward zero and flushes subnormals to signed zero.
// Optional feature macro: SCI_ALU_MUL_EN (enables the 53x53 multiplier;
// when undefined, opcode 2 is reserved).
module scientific_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  input  logic [3:0]  opcode,
  output logic [63:0] result_out,
  output logic        excep,
  output logic        err
);

  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_ONE = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] NEG_ONE = 64'hBFF0_0000_0000_0000;

  // Operand field extraction; subnormal mantissas are forced to zero
  logic        a_sign, b_sign;
  logic [10:0] a_exp, b_exp;
  logic [51:0] a_man, b_man;
  logic        a_inf, b_inf, a_nan, b_nan;

  assign a_sign = a_in[63];
  assign b_sign = b_in[63];
  assign a_exp  = a_in[62:52];
  assign b_exp  = b_in[62:52];
  assign a_man  = (a_exp == 11'd0) ? 52'd0 : a_in[51:0];
  assign b_man  = (b_exp == 11'd0) ? 52'd0 : b_in[51:0];
  assign a_inf  = (a_exp == 11'h7FF) && (a_in[51:0] == 52'd0);
  assign b_inf  = (b_exp == 11'h7FF) && (b_in[51:0] == 52'd0);
  assign a_nan  = (a_exp == 11'h7FF) && (a_in[51:0] != 52'd0);
  assign b_nan  = (b_exp == 11'h7FF) && (b_in[51:0] != 52'd0);

  // Add/sub datapath: align with guard/round/sticky so truncation is exact RTZ
  logic        b_sign_eff, swap, s_big, eff_sub, sticky;
  logic [10:0] e_big, e_small, e_diff;
  logic [51:0] man_big, man_small;
  logic [55:0] m_big, m_small, m_shift;
  logic [56:0] sum, norm;
  logic signed [12:0] e_res;
  int          lead;
  logic [63:0] add_res;

  always_comb begin
    add_res    = 64'd0;
    b_sign_eff = b_sign ^ (opcode == 4'd1);
    swap       = {b_exp, b_man} > {a_exp, a_man};
    e_big      = swap ? b_exp : a_exp;
    e_small    = swap ? a_exp : b_exp;
    man_big    = swap ? b_man : a_man;
    man_small  = swap ? a_man : b_man;
    s_big      = swap ? b_sign_eff : a_sign;
    m_big      = {(e_big != 11'd0), man_big, 3'b000};
    m_small    = {(e_small != 11'd0), man_small, 3'b000};
    e_diff     = e_big - e_small;
    if (e_diff >= 11'd56) begin
      m_shift = 56'd0;
      sticky  = |m_small;
    end else begin
      m_shift = m_small >> e_diff;
      sticky  = |(m_small << (11'd56 - e_diff));
    end
    m_shift[0] = m_shift[0] | sticky;
    eff_sub    = a_sign ^ b_sign_eff;
    sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_shift})
                  : ({1'b0, m_big} + {1'b0, m_shift});
    lead = 0;
    for (int i = 0; i < 57; i++) begin
      if (sum[i]) lead = i;
    end
    if (lead == 56) norm = sum >> 1;
    else            norm = sum << (55 - lead);
    e_res = $signed({2'b00, e_big}) + 13'(lead - 55);
    if (a_nan || b_nan)                              add_res = QNAN;
    else if (a_inf && b_inf && (a_sign != b_sign_eff)) add_res = QNAN;
    else if (a_inf)                                  add_res = {a_sign, 11'h7FF, 52'd0};
    else if (b_inf)                                  add_res = {b_sign_eff, 11'h7FF, 52'd0};
    else if (sum == 57'd0)                           add_res = 64'd0;
    else if (e_res <= 13'sd0)                        add_res = {s_big, 63'd0};
    else if (e_res >= 13'sd2047)                     add_res = {s_big, 11'h7FF, 52'd0};
    else                                             add_res = {s_big, e_res[10:0], norm[54:3]};
  end

`ifdef SCI_ALU_MUL_EN
  // Multiplier datapath: 53x53 product, truncated, with overflow/underflow handling
  logic [105:0] prod;
  logic         p_sign;
  logic signed [12:0] e_mul;
  logic [51:0]  p_man;
  logic [63:0]  mul_res;
  logic         unused_prod;

  always_comb begin
    mul_res = 64'd0;
    prod    = {1'b1, a_man} * {1'b1, b_man};
    p_sign  = a_sign ^ b_sign;
    e_mul   = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 13'sd1023
              + (prod[105] ? 13'sd1 : 13'sd0);
    p_man   = prod[105] ? prod[104:53] : prod[103:52];
    if (a_nan || b_nan)                                    mul_res = QNAN;
    else if ((a_inf && b_exp == 11'd0) || (b_inf && a_exp == 11'd0)) mul_res = QNAN;
    else if (a_inf || b_inf)                               mul_res = {p_sign, 11'h7FF, 52'd0};
    else if (a_exp == 11'd0 || b_exp == 11'd0)             mul_res = {p_sign, 63'd0};
    else if (e_mul <= 13'sd0)                              mul_res = {p_sign, 63'd0};
    else if (e_mul >= 13'sd2047)                           mul_res = {p_sign, 11'h7FF, 52'd0};
    else                                                   mul_res = {p_sign, e_mul[10:0], p_man};
  end

  assign unused_prod = ^prod[51:0];
`endif

  // Ordering keys: sign-magnitude mapped to two's complement so +0 == -0
  logic signed [63:0] key_a, key_b;
  logic               a_gt, a_lt, any_nan;
  logic [63:0]        a_flush, b_flush;
  logic               unused_bits;

  assign key_a   = a_sign ? -$signed({1'b0, a_exp, a_man}) : $signed({1'b0, a_exp, a_man});
  assign key_b   = b_sign ? -$signed({1'b0, b_exp, b_man}) : $signed({1'b0, b_exp, b_man});
  assign a_gt    = key_a > key_b;
  assign a_lt    = key_a < key_b;
  assign any_nan = a_nan || b_nan;
  assign a_flush = {a_sign, a_exp, a_man};
  assign b_flush = {b_sign, b_exp, b_man};
  assign unused_bits = ^{norm[56:55], norm[2:0]};

  // Opcode decode into the next result and error flag
  logic [63:0] res_d;
  logic        err_d, excep_d;

  always_comb begin
    res_d = 64'd0;
    err_d = 1'b0;
    case (opcode)
      4'd0, 4'd1: res_d = add_res;
`ifdef SCI_ALU_MUL_EN
      4'd2:       res_d = mul_res;
`else
      4'd2:       err_d = 1'b1;
`endif
      4'd3:       res_d = {~a_in[63], a_in[62:0]};
      4'd4:       res_d = {1'b0, a_in[62:0]};
      4'd5:       res_d = any_nan ? QNAN : (a_gt ? b_flush : a_flush);
      4'd6:       res_d = any_nan ? QNAN : (a_lt ? b_flush : a_flush);
      4'd7:       res_d = any_nan ? QNAN : (a_gt ? POS_ONE : (a_lt ? NEG_ONE : 64'd0));
      4'd8:       res_d = a_in;
      4'd9:       res_d = b_in;
      default:    err_d = 1'b1;
    endcase
    excep_d = (res_d[62:52] == 11'h7FF);
  end

  // Output register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_out <= 64'd0;
      excep      <= 1'b0;
      err        <= 1'b0;
    end else begin
      result_out <= res_d;
      excep      <= excep_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_scientific_alu.sv
// Self-checking bench for scientific_alu using an expected-result queue.
// Honours SCI_ALU_MUL_EN to select opcode 2 expectations.
module tb_scientific_alu;

  localparam logic [63:0] F16     = 64'h4030_0000_0000_0000;
  localparam logic [63:0] F2      = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F1      = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] FM1     = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] F18     = 64'h4032_0000_0000_0000;
  localparam logic [63:0] F1E308  = 64'h7FE1_CCF3_85EB_C8A0;
  localparam logic [63:0] PINF    = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] NZERO   = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic [63:0] a_in, b_in;
  logic [3:0]  opcode;
  logic [63:0] result_out;
  logic        excep, err;

  typedef struct {
    logic [63:0] res;
    logic        ex;
    logic        er;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  scientific_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .opcode     (opcode),
    .result_out (result_out),
    .excep      (excep),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] op, input logic [63:0] res,
                               input logic ex, input logic er);
    exp_t e;
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    opcode = op;
    e.res = res;
    e.ex  = ex;
    e.er  = er;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Each captured operation is checked just after the edge that registers it
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      cur = sb.pop_front();
      checkOutput({cur.tag, "_res"}, result_out, cur.res);
      checkOutput({cur.tag, "_excep"}, {63'd0, excep}, {63'd0, cur.ex});
      checkOutput({cur.tag, "_err"}, {63'd0, err}, {63'd0, cur.er});
    end
  end

  logic [63:0] step_res [10];
  logic        mul_err;

  initial begin
    rst_n  = 1'b0;
    a_in   = F16;
    b_in   = F2;
    opcode = 4'd0;
`ifdef SCI_ALU_MUL_EN
    step_res[2] = 64'h4040_0000_0000_0000;
    mul_err     = 1'b0;
`else
    step_res[2] = 64'd0;
    mul_err     = 1'b1;
`endif
    step_res[0] = F18;
    step_res[1] = 64'h402C_0000_0000_0000;
    step_res[3] = 64'hC030_0000_0000_0000;
    step_res[4] = F16;
    step_res[5] = F2;
    step_res[6] = F16;
    step_res[7] = F1;
    step_res[8] = F16;
    step_res[9] = F2;

    #3;
    checkOutput("reset_res", result_out, 64'd0);
    checkOutput("reset_excep", {63'd0, excep}, 64'd0);
    checkOutput("reset_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      applyStimulus($sformatf("step_op%0d", i), F16, F2, 4'(i), step_res[i], 1'b0,
                    (i == 2) ? mul_err : 1'b0);
    for (int i = 10; i < 16; i++)
      applyStimulus($sformatf("rsvd_op%0d", i), F16, F2, 4'(i), 64'd0, 1'b0, 1'b1);

    applyStimulus("ovf_add", F1E308, F1E308, 4'd0, PINF, 1'b1, 1'b0);
    applyStimulus("inf_sub_inf", PINF, PINF, 4'd1, QNAN, 1'b1, 1'b0);
    applyStimulus("neg_nan", QNAN, F2, 4'd3, 64'hFFF8_0000_0000_0000, 1'b1, 1'b0);
    applyStimulus("cancel_zero", F1, FM1, 4'd0, 64'd0, 1'b0, 1'b0);
    applyStimulus("cmp_signed_zero", NZERO, 64'd0, 4'd7, 64'd0, 1'b0, 1'b0);
    applyStimulus("cmp_less", F2, F16, 4'd7, FM1, 1'b0, 1'b0);
    applyStimulus("trunc_add", F1, 64'h3CB8_0000_0000_0000, 4'd0, 64'h3FF0_0000_0000_0001, 1'b0, 1'b0);
    applyStimulus("trunc_sub", F1, 64'h3C30_0000_0000_0000, 4'd1, 64'h3FEF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("uflow_sub", 64'h0018_0000_0000_0000, 64'h0010_0000_0000_0000, 4'd1, 64'd0, 1'b0, 1'b0);
    applyStimulus("subnorm_in", 64'h0000_0000_0000_0001, F1, 4'd0, F1, 1'b0, 1'b0);
    applyStimulus("inf_plus_one", PINF, F1, 4'd0, PINF, 1'b1, 1'b0);
    applyStimulus("min_nan", F1, QNAN | 64'h1, 4'd5, QNAN, 1'b1, 1'b0);
    applyStimulus("min_neg", F16, FM1, 4'd5, FM1, 1'b0, 1'b0);
    applyStimulus("max_neg", FM1, F2, 4'd6, F2, 1'b0, 1'b0);
    applyStimulus("abs_neg", FM1, F2, 4'd4, F1, 1'b0, 1'b0);
    applyStimulus("pass_inf", PINF, F2, 4'd8, PINF, 1'b1, 1'b0);
`ifdef SCI_ALU_MUL_EN
    applyStimulus("ovf_mul", F1E308, F1E308, 4'd2, PINF, 1'b1, 1'b0);
    applyStimulus("zero_mul_inf", 64'd0, PINF, 4'd2, QNAN, 1'b1, 1'b0);
    applyStimulus("uflow_mul", 64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 4'd2, 64'd0, 1'b0, 1'b0);
    applyStimulus("mul_neg", FM1, F16, 4'd2, 64'hC030_0000_0000_0000, 1'b0, 1'b0);
`else
    applyStimulus("mul_disabled", F1E308, F1E308, 4'd2, 64'd0, 1'b0, 1'b1);
`endif
    applyStimulus("pre_reset_add", F16, F2, 4'd0, F18, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_res", result_out, 64'd0);
    checkOutput("async_rst_excep", {63'd0, excep}, 64'd0);
    checkOutput("async_rst_err", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("held_rst_res", result_out, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    cur.res = F18;
    cur.ex  = 1'b0;
    cur.er  = 1'b0;
    cur.tag = "post_reset_add";
    sb.push_back(cur);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
